eth_tx_packer: RTL

ETH_TX_PACKER -- requirements
Module: eth_tx_packer

---
 rtl/eth_tx_packer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/eth_tx_packer.sv
// eth_tx_packer: packs a byte stream into length-prefixed frames for an Ethernet MAC.
// Ports: i_clk/i_rst (sync active-high); i_wdata/i_wvalid/o_wready payload input;
//        o_tx_data/o_tx_valid/o_tx_last/i_tx_ready framed output.
// Optional: define ETH_TX_PACKER_CHK_EN to append an XOR checksum byte to each frame.
module eth_tx_packer #(
  parameter int DEPTH       = 256,
  parameter int IDLE_CYCLES = 64,
  parameter int MAX_LEN     = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_wdata,
  input  logic       i_wvalid,
  output logic       o_wready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic       o_tx_last
);
  localparam int AW = $clog2(DEPTH);
`ifdef ETH_TX_PACKER_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, PAYLOAD
`ifdef ETH_TX_PACKER_CHK_EN
    , CHK
`endif
  } state_t;
  logic [7:0]  r_mem [DEPTH];
  logic [15:0] r_lq [4];
  logic [AW:0] r_wp, r_rp;
  logic [2:0]  r_lwp, r_lrp;
  logic [15:0] r_len, r_idle, r_rem;
`ifdef ETH_TX_PACKER_CHK_EN
  logic [7:0]  r_chk;
`endif
  state_t      r_st;
  logic        w_full, w_lq_full, w_lq_empty, w_acc, w_close;
  logic [15:0] w_len_nx, w_head;
  logic [7:0]  w_byte;
  // extra pointer MSB separates full (MSBs differ) from empty (pointers equal)
  assign w_full     = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_lq_full  = (r_lwp[2] != r_lrp[2]) && (r_lwp[1:0] == r_lrp[1:0]);
  assign w_lq_empty = r_lwp == r_lrp;
  assign o_wready   = !i_rst && !w_full && !w_lq_full;
  assign w_acc      = i_wvalid && o_wready;
  assign w_len_nx   = r_len + 16'(w_acc);
  // an idle-timed-out frame waits for a free length slot before it closes
  assign w_close    = !w_lq_full && (w_len_nx != 16'd0) &&
                      ((w_len_nx == 16'(MAX_LEN)) || (!w_acc && r_idle == 16'(IDLE_CYCLES)));
  assign w_head     = r_lq[r_lrp[1:0]];
  assign w_byte     = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge i_clk) begin
    if (w_acc) r_mem[r_wp[AW-1:0]] <= i_wdata;
    if (w_close) r_lq[r_lwp[1:0]] <= w_len_nx;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp   <= '0;
      r_lwp  <= '0;
      r_len  <= '0;
      r_idle <= '0;
    end else begin
      r_wp   <= r_wp + (AW+1)'(w_acc);
      r_lwp  <= r_lwp + 3'(w_close);
      r_len  <= w_close ? 16'd0 : w_len_nx;
      r_idle <= w_acc ? 16'd0 : (r_idle == 16'(IDLE_CYCLES) ? r_idle : r_idle + 16'd1);
    end
  end
  // r_rem holds the frame length in LEN_HI/LEN_LO, then the payload bytes left after the current one
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st       <= IDLE;
      r_rp       <= '0;
      r_lrp      <= '0;
      r_rem      <= '0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      o_tx_last  <= 1'b0;
`ifdef ETH_TX_PACKER_CHK_EN
      r_chk      <= '0;
`endif
    end else begin
      case (r_st)
        IDLE: if (!w_lq_empty) begin
          r_st       <= LEN_HI;
          r_rem      <= w_head;
          o_tx_data  <= w_head[15:8];
          o_tx_valid <= 1'b1;
        end
        LEN_HI: if (o_tx_valid && i_tx_ready) begin
          r_st      <= LEN_LO;
          o_tx_data <= r_rem[7:0];
        end
        LEN_LO: if (o_tx_valid && i_tx_ready) begin
          r_st      <= PAYLOAD;
          o_tx_data <= w_byte;
          o_tx_last <= (r_rem == 16'd1) && !CHK_EN;
          r_rp      <= r_rp + 1'b1;
          r_rem     <= r_rem - 16'd1;
`ifdef ETH_TX_PACKER_CHK_EN
          r_chk     <= w_byte;
`endif
        end
        PAYLOAD: if (o_tx_valid && i_tx_ready) begin
          if (r_rem == 16'd0) begin
`ifdef ETH_TX_PACKER_CHK_EN
            r_st       <= CHK;
            o_tx_data  <= r_chk;
            o_tx_last  <= 1'b1;
`else
            r_st       <= IDLE;
            r_lrp      <= r_lrp + 3'd1;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
            o_tx_last  <= 1'b0;
`endif
          end else begin
            o_tx_data <= w_byte;
            o_tx_last <= (r_rem == 16'd1) && !CHK_EN;
            r_rp      <= r_rp + 1'b1;
            r_rem     <= r_rem - 16'd1;
`ifdef ETH_TX_PACKER_CHK_EN
            r_chk     <= r_chk ^ w_byte;
`endif
          end
        end
`ifdef ETH_TX_PACKER_CHK_EN
        CHK: if (o_tx_valid && i_tx_ready) begin
          r_st       <= IDLE;
          r_lrp      <= r_lrp + 3'd1;
          o_tx_data  <= '0;
          o_tx_valid <= 1'b0;
          o_tx_last  <= 1'b0;
        end
`endif
        default: r_st <= IDLE;
      endcase
    end
  end
endmodule
